// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. It sends one command byte to the keyboard
// using the host-request protocol: inhibit the clock, assert the start bit,
// release the clock, then shift the frame out on device clock falls and check
// the device ACK. The lines are driven through active-high pull-low enables.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 6000,     // must be >= 2
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int FILTER_LEN     = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error
);

   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;
   localparam int FLT_W   = $clog2(FILTER_LEN) + 1;

   // The start bit goes out one cycle before the inhibit ends, so the clock
   // stays low for exactly INHIBIT_CYCLES with both lines low in the last one.
   localparam logic [CNT_W-1:0] INHIBIT_DAT_CNT = CNT_W'(INHIBIT_CYCLES - 2);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SAT         = {CNT_W{1'b1}};
   localparam logic [FLT_W-1:0] FLT_LAST        = FLT_W'(FILTER_LEN - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      INHIBIT   = 3'd1,
      START     = 3'd2,
      SEND      = 3'd3,
      ACK       = 3'd4,
      WAIT_IDLE = 3'd5,
      ERROR     = 3'd6
   } state_t;

   // Odd parity: the bit that makes the total count of ones in data+parity odd.
   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

   logic [1:0]       clk_sync_r;
   logic [1:0]       dat_sync_r;
   logic             clk_filt_r;
   logic [FLT_W-1:0] flt_cnt_r;
   logic             fall_r;

   state_t           state_r;
   logic [9:0]       frame_r;
   logic [3:0]       bit_idx_r;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_inc_s;
   logic             timeout_s;
   logic             clk_oe_r;
   logic             dat_oe_r;
   logic             busy_r;
   logic             done_r;
   logic             error_r;

   // Two-flop synchronizers for the asynchronous pin levels; idle bus reads high.
   always_ff @(posedge clock) begin
      if (reset) begin
         clk_sync_r <= 2'b11;
         dat_sync_r <= 2'b11;
      end else begin
         clk_sync_r <= {clk_sync_r[0], ps2_clk_in};
         dat_sync_r <= {dat_sync_r[0], ps2_dat_in};
      end
   end

   // Clock deglitch: the filtered level flips after FILTER_LEN consecutive differing samples.
   always_ff @(posedge clock) begin
      if (reset) begin
         clk_filt_r <= 1'b1;
         flt_cnt_r  <= {FLT_W{1'b0}};
         fall_r     <= 1'b0;
      end else if (clk_sync_r[1] == clk_filt_r) begin
         flt_cnt_r  <= {FLT_W{1'b0}};
         fall_r     <= 1'b0;
      end else if (flt_cnt_r == FLT_LAST) begin
         clk_filt_r <= clk_sync_r[1];
         flt_cnt_r  <= {FLT_W{1'b0}};
         fall_r     <= clk_filt_r;
      end else begin
         flt_cnt_r  <= flt_cnt_r + FLT_W'(1);
         fall_r     <= 1'b0;
      end
   end

   // Saturating increment and timeout terminal count for the shared cycle counter.
   always_comb begin
      cnt_inc_s = cnt_r;
      if (cnt_r != CNT_SAT) begin
         cnt_inc_s = cnt_r + CNT_W'(1);
      end else begin
         cnt_inc_s = cnt_r;
      end
      timeout_s = (cnt_r == TIMEOUT_LAST);
   end

   // Transmit sequencer; every output is a register so the pin enables never glitch.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r   <= IDLE;
         frame_r   <= 10'd0;
         bit_idx_r <= 4'd0;
         cnt_r     <= {CNT_W{1'b0}};
         clk_oe_r  <= 1'b0;
         dat_oe_r  <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         error_r   <= 1'b0;
      end else begin
         done_r  <= 1'b0;
         error_r <= 1'b0;
         case (state_r)
            IDLE: begin
               clk_oe_r <= 1'b0;
               dat_oe_r <= 1'b0;
               busy_r   <= 1'b0;
               if (tx_start) begin
                  frame_r   <= {1'b1, odd_parity(tx_data), tx_data};
                  bit_idx_r <= 4'd0;
                  cnt_r     <= {CNT_W{1'b0}};
                  clk_oe_r  <= 1'b1;
                  busy_r    <= 1'b1;
                  state_r   <= INHIBIT;
               end
            end
            INHIBIT: begin
               cnt_r <= cnt_inc_s;
               if (cnt_r == INHIBIT_DAT_CNT) begin
                  dat_oe_r <= 1'b1;
                  state_r  <= START;
               end
            end
            START: begin
               clk_oe_r <= 1'b0;
               cnt_r    <= {CNT_W{1'b0}};
               state_r  <= SEND;
            end
            SEND: begin
               // A fall wins over a coincident timeout.
               if (fall_r) begin
                  cnt_r     <= {CNT_W{1'b0}};
                  dat_oe_r  <= ~frame_r[bit_idx_r];
                  bit_idx_r <= bit_idx_r + 4'd1;
                  if (bit_idx_r == 4'd9) begin
                     state_r <= ACK;
                  end
               end else if (timeout_s) begin
                  dat_oe_r <= 1'b0;
                  error_r  <= 1'b1;
                  state_r  <= ERROR;
               end else begin
                  cnt_r <= cnt_inc_s;
               end
            end
            ACK: begin
               if (fall_r) begin
                  cnt_r     <= {CNT_W{1'b0}};
                  bit_idx_r <= bit_idx_r + 4'd1;
                  if (dat_sync_r[1] == 1'b0) begin
                     state_r <= WAIT_IDLE;
                  end else begin
                     error_r <= 1'b1;
                     state_r <= ERROR;
                  end
               end else if (timeout_s) begin
                  error_r <= 1'b1;
                  state_r <= ERROR;
               end else begin
                  cnt_r <= cnt_inc_s;
               end
            end
            WAIT_IDLE: begin
               if (clk_filt_r && dat_sync_r[1]) begin
                  done_r  <= 1'b1;
                  state_r <= IDLE;
               end else if (fall_r) begin
                  cnt_r <= {CNT_W{1'b0}};
               end else if (timeout_s) begin
                  error_r <= 1'b1;
                  state_r <= ERROR;
               end else begin
                  cnt_r <= cnt_inc_s;
               end
            end
            ERROR: begin
               clk_oe_r <= 1'b0;
               dat_oe_r <= 1'b0;
               busy_r   <= 1'b0;
               state_r  <= IDLE;
            end
            default: begin
               clk_oe_r <= 1'b0;
               dat_oe_r <= 1'b0;
               busy_r   <= 1'b0;
               state_r  <= IDLE;
            end
         endcase
      end
   end

   assign ps2_clk_oe = clk_oe_r;
   assign ps2_dat_oe = dat_oe_r;
   assign tx_busy    = busy_r;
   assign tx_done    = done_r;
   assign tx_error   = error_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on the pins.
module tb_ps2_host_tx;

   localparam int TIMEOUT = 2000;
   localparam int H       = 40;   // device clock half period in system cycles

   logic       clock;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       ps2_clk_in;
   logic       ps2_dat_in;
   logic       ps2_clk_oe;
   logic       ps2_dat_oe;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_error;

   logic       dev_clk;
   logic       dev_dat;

   int tests;
   int failed;
   int done_cnt;
   int err_cnt;

   ps2_host_tx #(
      .INHIBIT_CYCLES(6000),
      .TIMEOUT_CYCLES(TIMEOUT),
      .FILTER_LEN    (8)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .tx_data   (tx_data),
      .tx_start  (tx_start),
      .ps2_clk_in(ps2_clk_in),
      .ps2_dat_in(ps2_dat_in),
      .ps2_clk_oe(ps2_clk_oe),
      .ps2_dat_oe(ps2_dat_oe),
      .tx_busy   (tx_busy),
      .tx_done   (tx_done),
      .tx_error  (tx_error)
   );

   // open-drain bus: low if either side pulls
   assign ps2_clk_in = ~ps2_clk_oe & dev_clk;
   assign ps2_dat_in = ~ps2_dat_oe & dev_dat;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // pulse counters
   always @(posedge clock) begin
      if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
      if (tx_error === 1'b1) err_cnt <= err_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests = tests + 1;
      assert (obs === exp) else begin
         failed = failed + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_tx(input logic [7:0] d);
      @(negedge clock);
      check("busy_before_start", {31'd0, tx_busy}, 32'd0);
      tx_data  = d;
      tx_start = 1'b1;
      @(negedge clock);
      tx_start = 1'b0;
      check("busy_after_accept", {31'd0, tx_busy}, 32'd1);
   endtask

   // counts cycles of clock inhibit until the host releases the clock line
   task automatic wait_release();
      int n;
      n = 0;
      while (ps2_clk_oe === 1'b1 && n < 20000) begin
         n = n + 1;
         @(negedge clock);
      end
      check("inhibit_len", n, 32'd6000);
      check("start_bit_at_release", {31'd0, ps2_dat_oe}, 32'd1);
   endtask

   // device clocks npulses; samples data at the end of each high phase;
   // returns right after the last falling edge with the clock held low.
   // ev_kind 1: 3-cycle glitch in pulse ev_pulse; 2: tx_start 0x00 in that pulse
   task automatic device_clock(input bit nack, input int ev_pulse, input int ev_kind,
                               input int npulses, output logic [10:0] bits);
      logic oe_before;
      bits = 11'd0;
      for (int p = 1; p <= npulses; p++) begin
         if (p == ev_pulse && ev_kind == 1) begin
            repeat (H / 2) @(negedge clock);
            oe_before = ps2_dat_oe;
            dev_clk = 1'b0;
            repeat (3) @(negedge clock);
            dev_clk = 1'b1;
            repeat (H / 2 - 3) @(negedge clock);
            check("glitch_no_advance", {31'd0, ps2_dat_oe}, {31'd0, oe_before});
         end else if (p == ev_pulse && ev_kind == 2) begin
            repeat (H / 2) @(negedge clock);
            tx_data  = 8'h00;
            tx_start = 1'b1;
            @(negedge clock);
            tx_start = 1'b0;
            repeat (H / 2 - 1) @(negedge clock);
            check("busy_during_send", {31'd0, tx_busy}, 32'd1);
         end else begin
            repeat (H) @(negedge clock);
         end
         bits[p-1] = ps2_dat_in;
         if (p == 11 && !nack) dev_dat = 1'b0;
         dev_clk = 1'b0;
         if (p < npulses) begin
            repeat (H) @(negedge clock);
            dev_clk = 1'b1;
         end
      end
   endtask

   task automatic device_release();
      repeat (H) @(negedge clock);
      dev_clk = 1'b1;
      dev_dat = 1'b1;
   endtask

   task automatic wait_outcome();
      int n;
      n = 0;
      while (tx_done !== 1'b1 && tx_error !== 1'b1 && n < 1000) begin
         @(negedge clock);
         n = n + 1;
      end
   endtask

   task automatic run_ack_frame(input logic [7:0] d, input logic [10:0] exp_bits,
                                input int ev_pulse, input int ev_kind);
      logic [10:0] bits;
      int d0;
      d0 = done_cnt;
      start_tx(d);
      wait_release();
      device_clock(1'b0, ev_pulse, ev_kind, 11, bits);
      check("frame_bits", {21'd0, bits}, {21'd0, exp_bits});
      device_release();
      wait_outcome();
      check("done_pulse", {31'd0, tx_done}, 32'd1);
      check("no_error_on_ack", {31'd0, tx_error}, 32'd0);
      check("busy_through_done", {31'd0, tx_busy}, 32'd1);
      @(negedge clock);
      check("done_one_cycle", {31'd0, tx_done}, 32'd0);
      check("busy_drop_after_done", {31'd0, tx_busy}, 32'd0);
      check("done_count", done_cnt - d0, 32'd1);
   endtask

   initial begin
      logic [10:0] bits;
      int d0;
      int e0;
      int k;
      tests    = 0;
      failed   = 0;
      done_cnt = 0;
      err_cnt  = 0;
      reset    = 1'b1;
      tx_start = 1'b0;
      tx_data  = 8'h00;
      dev_clk  = 1'b1;
      dev_dat  = 1'b1;
      repeat (3) @(negedge clock);
      check("reset_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
      check("reset_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
      check("reset_busy", {31'd0, tx_busy}, 32'd0);
      check("reset_pulses", {30'd0, tx_done, tx_error}, 32'd0);
      reset = 1'b0;
      repeat (5) @(negedge clock);

      // 0xED set-LEDs: start 0, data 1,0,1,1,0,1,1,1, parity 1, stop 1
      run_ack_frame(8'hED, 11'b11111011010, 0, 0);

      // 0xF4 enable: data 0,0,1,0,1,1,1,1, parity 0
      run_ack_frame(8'hF4, 11'b10111101000, 0, 0);

      // NACK: device leaves data high at the 11th clock
      d0 = done_cnt;
      e0 = err_cnt;
      start_tx(8'hEE);
      wait_release();
      device_clock(1'b1, 0, 0, 11, bits);
      check("nack_frame_bits", {21'd0, bits}, {21'd0, 11'b11111011100});
      wait_outcome();
      check("nack_error", {31'd0, tx_error}, 32'd1);
      check("nack_no_done", {31'd0, tx_done}, 32'd0);
      check("nack_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
      @(negedge clock);
      check("nack_error_one_cycle", {31'd0, tx_error}, 32'd0);
      check("nack_busy_drop", {31'd0, tx_busy}, 32'd0);
      device_release();
      repeat (50) @(negedge clock);
      check("nack_done_count", done_cnt - d0, 32'd0);
      check("nack_error_count", err_cnt - e0, 32'd1);

      // timeout: device never clocks
      start_tx(8'hFF);
      wait_release();
      k = 0;
      while (tx_error !== 1'b1 && k < 3000) begin
         @(negedge clock);
         k = k + 1;
      end
      check("timeout_latency", k, TIMEOUT);
      check("timeout_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
      @(negedge clock);
      check("timeout_back_idle", {31'd0, tx_busy}, 32'd0);

      // tx_start with 0x00 during SEND is ignored
      run_ack_frame(8'h81, 11'b11100000010, 4, 2);

      // 3-cycle clock glitch mid-frame
      run_ack_frame(8'hA5, 11'b11101001010, 6, 1);

      // reset at the 5th device fall
      d0 = done_cnt;
      e0 = err_cnt;
      start_tx(8'h55);
      wait_release();
      device_clock(1'b0, 0, 0, 5, bits);
      reset = 1'b1;
      @(negedge clock);
      check("reset_mid_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
      check("reset_mid_busy", {31'd0, tx_busy}, 32'd0);
      reset   = 1'b0;
      dev_clk = 1'b1;
      repeat (100) @(negedge clock);
      check("reset_mid_no_pulses", (done_cnt - d0) + (err_cnt - e0), 32'd0);

      // next transfer after reset works
      run_ack_frame(8'h3C, 11'b11001111000, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
